sha256_host_ctrl: RTL and testbench

- Host-side counterpart of simplified_sha256.
- Loads a message into the shared dpsram over the memory port, starts the hasher and waits for done.
- Reads the 8-word digest back from dpsram and returns it on a valid/ready stream.
- Owns the single dpsram port. While the hasher runs, it forwards the hasher's memory requests to that port.

---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_host_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_sha256_host_ctrl.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types and defaults for the SHA-256 host controller.
// Imported by the controller and anything that wants its constants.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    HASH,
    RD_ADDR,
    RD_DATA,
    OUT
  } host_state_t;

  localparam logic [15:0] MESSAGE_ADDR_DEF   = 16'd0;
  localparam logic [15:0] OUTPUT_ADDR_DEF    = 16'd1000;
  localparam int          NUM_OF_WORDS_DEF   = 20;
  localparam int          NUM_HASH_WORDS_DEF = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sha256_host_ctrl.sv
// Host side of simplified_sha256: loads the message into dpsram, kicks
// the hasher, then streams the digest back out on a valid/ready port.
module sha256_host_ctrl
  import sha256_pkg::*;
#(
  parameter int          NUM_OF_WORDS   = NUM_OF_WORDS_DEF,
  parameter logic [15:0] MESSAGE_ADDR   = MESSAGE_ADDR_DEF,
  parameter logic [15:0] OUTPUT_ADDR    = OUTPUT_ADDR_DEF,
  parameter int          NUM_HASH_WORDS = NUM_HASH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        sha_start,
  output logic [15:0] sha_message_addr,
  output logic [15:0] sha_output_addr,
  input  logic        sha_done,
  input  logic        sha_mem_we,
  input  logic [15:0] sha_mem_addr,
  input  logic [31:0] sha_mem_write_data,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int CW =
    $clog2(max2(NUM_OF_WORDS, NUM_HASH_WORDS)) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LAST_IN  = cnt_t'(NUM_OF_WORDS - 1);
  localparam cnt_t LAST_OUT = cnt_t'(NUM_HASH_WORDS - 1);
  localparam cnt_t ONE      = cnt_t'(1);
  localparam cnt_t START_END = cnt_t'(2);

  if ((int'(MESSAGE_ADDR) + NUM_OF_WORDS - 1 > 65535) ||
      (int'(OUTPUT_ADDR) + NUM_HASH_WORDS - 1 > 65535))
  begin : g_addr_range
    $error("sha256_host_ctrl: address range wraps 16 bits");
  end

  host_state_t state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [31:0] out_data_q, out_data_d;
  logic        busy_q, busy_d;
  logic        sha_start_q, sha_start_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      sha_start_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      sha_start_q <= sha_start_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    sha_start_d = sha_start_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        mem_we_d = 1'b0;
        if (in_xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = MESSAGE_ADDR;
          mem_wdata_d = in_data;
          cnt_d       = ONE;
          busy_d      = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        mem_we_d = in_xfer;
        if (in_xfer) begin
          mem_addr_d  = MESSAGE_ADDR + 16'(cnt_q);
          mem_wdata_d = in_data;
          cnt_d       = cnt_q + ONE;
          if (cnt_q == LAST_IN) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
      end
      // Phase 0 lets the final write land; phases 1-2 hold sha_start.
      START: begin
        mem_we_d = 1'b0;
        cnt_d    = cnt_q + ONE;
        if (cnt_q == '0) begin
          sha_start_d = 1'b1;
        end
        if (cnt_q == START_END) begin
          sha_start_d = 1'b0;
          cnt_d       = '0;
          state_d     = HASH;
        end
      end
      HASH: begin
        if (sha_done) begin
          cnt_d      = '0;
          mem_we_d   = 1'b0;
          mem_addr_d = OUTPUT_ADDR;
          state_d    = RD_ADDR;
        end
      end
      RD_ADDR: begin
        mem_we_d = 1'b0;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        out_data_d  = mem_read_data;
        out_valid_d = 1'b1;
        out_last_d  = (cnt_q == LAST_OUT);
        state_d     = OUT;
      end
      OUT: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d      = cnt_q + ONE;
            mem_addr_d = OUTPUT_ADDR + 16'(cnt_q + ONE);
            state_d    = RD_ADDR;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
  end

  // The hasher owns the dpsram port only while it is running.
  always_comb begin
    mem_we         = mem_we_q;
    mem_addr       = mem_addr_q;
    mem_write_data = mem_wdata_q;
    if (state_q == HASH) begin
      mem_we         = sha_mem_we;
      mem_addr       = sha_mem_addr;
      mem_write_data = sha_mem_write_data;
    end
  end

  assign mem_clk          = clk;
  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign out_last         = out_last_q;
  assign out_data         = out_data_q;
  assign busy             = busy_q;
  assign sha_start        = sha_start_q;
  assign sha_message_addr = MESSAGE_ADDR;
  assign sha_output_addr  = OUTPUT_ADDR;

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Bench for sha256_host_ctrl: dpsram model, stub hasher with a
// software SHA-256, and scenario tasks driven from one initial block.
module tb_sha256_host_ctrl;

  localparam int NW = 20;
  localparam int NH = 8;
  localparam logic [15:0] OBASE = 16'd1000;

  localparam logic [31:0] KC [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] HINIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        sha_start;
  logic [15:0] sha_message_addr;
  logic [15:0] sha_output_addr;
  logic        sha_done;
  logic        sha_mem_we;
  logic [15:0] sha_mem_addr;
  logic [31:0] sha_mem_write_data;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] dmem [0:65535];
  logic [31:0] msg [NW];
  logic [31:0] exp_dig [NH];
  logic [31:0] sha_in [NW];
  logic [31:0] sha_out [NH];

  int cyc = 0;
  int acc_q [$];
  int st_q [$];
  logic [15:0] wlog [$];

  always #5 clk = ~clk;

  sha256_host_ctrl dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_last           (out_last),
    .busy               (busy),
    .sha_start          (sha_start),
    .sha_message_addr   (sha_message_addr),
    .sha_output_addr    (sha_output_addr),
    .sha_done           (sha_done),
    .sha_mem_we         (sha_mem_we),
    .sha_mem_addr       (sha_mem_addr),
    .sha_mem_write_data (sha_mem_write_data),
    .mem_clk            (mem_clk),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_write_data     (mem_write_data),
    .mem_read_data      (mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= mem_write_data;
    mem_read_data <= dmem[mem_addr];
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset_n) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (sha_start) st_q.push_back(cyc);
      if (mem_we) wlog.push_back(mem_addr);
    end
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic sha_calc();
    logic [31:0] blk [32];
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 32; i++) blk[i] = 32'h0;
    for (int i = 0; i < NW; i++) blk[i] = sha_in[i];
    blk[NW] = 32'h8000_0000;
    blk[31] = 32'd640;
    for (int i = 0; i < 8; i++) h[i] = HINIT[i];
    for (int bi = 0; bi < 2; bi++) begin
      for (int t = 0; t < 16; t++) w[t] = blk[bi*16 + t];
      for (int t = 16; t < 64; t++) begin
        s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3];
      e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) +
             ((e & f) ^ (~e & g)) + KC[t] + w[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) +
             ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1;
        d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
      h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    for (int i = 0; i < 8; i++) sha_out[i] = h[i];
  endtask

  task automatic ref_digest();
    for (int i = 0; i < NW; i++) sha_in[i] = msg[i];
    sha_calc();
    for (int i = 0; i < NH; i++) exp_dig[i] = sha_out[i];
  endtask

  // Called at a negedge; returns at the negedge after the last accept.
  task automatic load_msg(input int n, input int gap_at);
    int g;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL gap_no_write cyc%0d: mem_we=%b want 0", k, mem_we);
          end
        end
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      g = 0;
      while (!in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) begin
        errors++;
        $display("FAIL load_timeout word %0d: in_ready=%b want 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_hash(output logic ok);
    int g = 0;
    while (!sha_start && g < 200) begin @(negedge clk); g++; end
    while (sha_start && g < 200) begin @(negedge clk); g++; end
    ok = (g < 200);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_timeout: sha_start never pulsed, got %0d cycles want <200", g);
    end
  endtask

  task automatic stub_sha();
    logic ok;
    wait_hash(ok);
    if (!ok) return;
    for (int i = 0; i < NW; i++) begin
      sha_mem_addr = 16'(i);
      @(negedge clk);
      sha_in[i] = mem_read_data;
    end
    sha_calc();
    for (int j = 0; j < NH; j++) begin
      sha_mem_we         = 1'b1;
      sha_mem_addr       = OBASE + 16'(j);
      sha_mem_write_data = sha_out[j];
      @(negedge clk);
    end
    sha_mem_we = 1'b0;
    sha_done   = 1'b1;
    @(negedge clk);
    sha_done   = 1'b0;
  endtask

  task automatic read_digest();
    int   k = 0;
    int   g = 0;
    logic held = 1'b0;
    logic was_xfer = 1'b0;
    logic r;
    while (k < NH && g < 600) begin
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_dig[k]) begin
          errors++;
          $display("FAIL hold_stable word %0d: valid=%b data=%h want valid=1 data=%h",
                   k, out_valid, out_data, exp_dig[k]);
        end
      end
      if (was_xfer) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_drop word %0d: out_valid=%b want 0", k, out_valid);
        end
      end
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      was_xfer = out_valid && r;
      held = out_valid && !r;
      if (was_xfer) begin
        checks++;
        if (out_data !== exp_dig[k] || out_last !== (k == NH-1) || busy !== 1'b1) begin
          errors++;
          $display("FAIL digest word %0d: data=%h last=%b busy=%b want data=%h last=%b busy=1",
                   k, out_data, out_last, busy, exp_dig[k], (k == NH-1));
        end
        k++;
      end
      @(negedge clk);
      g++;
    end
    out_ready = 1'b0;
    checks++;
    if (k < NH) begin
      errors++;
      $display("FAIL digest_timeout: got %0d words want %0d", k, NH);
    end else if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_last: valid=%b busy=%b in_ready=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (dmem[i] !== msg[i]) begin
        errors++;
        $display("FAIL %s dmem[%0d]: got %h want %h", tag, i, dmem[i], msg[i]);
      end
    end
  endtask

  task automatic check_start(input string tag, input int s0);
    int last_acc;
    last_acc = acc_q[acc_q.size()-1];
    checks++;
    if (st_q.size() - s0 != 2) begin
      errors++;
      $display("FAIL %s start_width: got %0d cycles want 2", tag, st_q.size() - s0);
    end else if (st_q[s0] != last_acc + 2 || st_q[s0+1] != last_acc + 3) begin
      errors++;
      $display("FAIL %s start_time: got %0d,%0d want %0d,%0d", tag,
               st_q[s0], st_q[s0+1], last_acc + 2, last_acc + 3);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++;
    if ({in_ready, out_valid, out_last, busy, sha_start, mem_we} !== 6'b0 ||
        mem_addr !== 16'h0 || mem_write_data !== 32'h0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b ov=%b ol=%b busy=%b st=%b we=%b a=%h d=%h od=%h want all 0",
               in_ready, out_valid, out_last, busy, sha_start, mem_we,
               mem_addr, mem_write_data, out_data);
    end
    checks++;
    if (sha_message_addr !== 16'd0 || sha_output_addr !== 16'd1000 || mem_clk !== clk) begin
      errors++;
      $display("FAIL const_ports: msg=%h out=%h mem_clk=%b clk=%b want 0000 03e8 equal",
               sha_message_addr, sha_output_addr, mem_clk, clk);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_full_system();
    int s0;
    msg[0] = 32'h01234567;
    for (int i = 1; i < NW; i++) msg[i] = {msg[i-1][30:0], msg[i-1][31]};
    msg[NW-1] = 32'h0;
    ref_digest();
    s0 = st_q.size();
    load_msg(NW, -1);
    stub_sha();
    check_mem("full");
    check_start("full", s0);
    read_digest();
  endtask

  task automatic test_hash_hold();
    int   s0;
    logic ok;
    logic [31:0] junk;
    for (int i = 0; i < NW; i++) msg[i] = $urandom;
    for (int i = 0; i < NH; i++) exp_dig[i] = 32'hA0 + 32'(i);
    junk = $urandom;
    s0 = st_q.size();
    load_msg(NW, -1);
    sha_mem_addr       = 16'h1234;
    sha_mem_we         = 1'b1;
    sha_mem_write_data = junk;
    in_valid = 1'b1;
    in_data  = ~junk;
    wait_hash(ok);
    if (ok) begin
      for (int c = 0; c < 500; c++) begin
        checks++;
        if (mem_addr !== 16'h1234 || mem_we !== 1'b1 ||
            mem_write_data !== junk || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL hash_fwd cyc%0d: a=%h we=%b d=%h rdy=%b want 1234 1 %h 0",
                   c, mem_addr, mem_we, mem_write_data, in_ready, junk);
        end
        @(negedge clk);
      end
      in_valid = 1'b0;
      for (int j = 0; j < NH; j++) begin
        sha_mem_addr       = OBASE + 16'(j);
        sha_mem_write_data = exp_dig[j];
        @(negedge clk);
      end
      sha_mem_we = 1'b0;
      sha_done   = 1'b1;
      @(negedge clk);
      sha_done   = 1'b0;
    end
    in_valid = 1'b0;
    sha_mem_we = 1'b0;
    check_start("hold", s0);
    read_digest();
    check_mem("hold");
  endtask

  task automatic test_back_to_back();
    int e;
    int a0;
    for (int i = 0; i < NW; i++) msg[i] = $urandom;
    ref_digest();
    e  = cyc + 1;
    a0 = acc_q.size();
    load_msg(NW, -1);
    checks++;
    if (acc_q.size() <= a0 || acc_q[a0] != e) begin
      errors++;
      $display("FAIL b2b_accept: first accept cyc=%0d want %0d",
               (acc_q.size() > a0) ? acc_q[a0] : -1, e);
    end
    stub_sha();
    check_mem("b2b");
    read_digest();
  endtask

  task automatic test_reset_midjob();
    int s0;
    int w0;
    for (int i = 0; i < NW; i++) msg[i] = $urandom;
    sha_done  = 1'b1;
    out_ready = 1'b1;
    load_msg(10, -1);
    checks++;
    if (out_valid !== 1'b0 || sha_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midjob_ignore: ov=%b st=%b busy=%b want 0 0 1",
               out_valid, sha_start, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, busy, sha_start, mem_we} !== 6'b0 ||
        mem_addr !== 16'h0 || mem_write_data !== 32'h0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL midjob_reset: rdy=%b ov=%b ol=%b busy=%b st=%b we=%b a=%h d=%h od=%h want all 0",
               in_ready, out_valid, out_last, busy, sha_start, mem_we,
               mem_addr, mem_write_data, out_data);
    end
    sha_done  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NW; i++) msg[i] = $urandom;
    ref_digest();
    s0 = st_q.size();
    w0 = wlog.size();
    load_msg(NW, 6);
    stub_sha();
    check_start("midjob", s0);
    for (int i = 0; i <= NW; i++) begin
      checks++;
      if (wlog.size() <= w0 + i) begin
        errors++;
        $display("FAIL midjob_wlog %0d: missing write want addr %0d", i,
                 (i < NW) ? i : 1000);
      end else if (wlog[w0+i] !== ((i < NW) ? 16'(i) : OBASE)) begin
        errors++;
        $display("FAIL midjob_wlog %0d: addr=%0d want %0d", i, wlog[w0+i],
                 (i < NW) ? i : 1000);
      end
    end
    checks++;
    if (dmem[6] !== msg[6]) begin
      errors++;
      $display("FAIL gap_word6: got %h want %h", dmem[6], msg[6]);
    end
    read_digest();
  endtask

  initial begin
    reset_n            = 1'b0;
    in_valid           = 1'b0;
    in_data            = 32'h0;
    out_ready          = 1'b0;
    sha_done           = 1'b0;
    sha_mem_we         = 1'b0;
    sha_mem_addr       = 16'h0;
    sha_mem_write_data = 32'h0;
    test_reset();
    test_full_system();
    test_hash_hold();
    test_back_to_back();
    test_reset_midjob();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
